// File: rtl/spm_dp_bank_pkg.sv
// Shared definitions for the dual-port scratchpad bank.
//   - default geometry (word-address width, data width)
//   - access strobe / direction encodings used on both ports
//   - read-latency limit and the clear-sequencer state type
package spm_dp_bank_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 2;

  // Strobe is active-low; direction high means read.
  localparam logic ENABLE_ = 1'b0;
  localparam logic READ    = 1'b1;
  localparam logic WRITE   = 1'b0;

  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    CLEAR    = 2'd1,
    IDLE     = 2'd2
  } spm_state_e;

endpackage

// File: rtl/spm_dp_bank_if.sv
// Bus bundle for the scratchpad: port A (instruction fetch), port B (load/store)
// and the shared ready flag.
//   master : drives address/strobe/direction/byte-enables/write data, sees read data/valid/ready
//   slave  : the scratchpad side
interface spm_dp_bank_if
  import spm_dp_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0]   if_spm_addr;
  logic                if_spm_as_;
  logic                if_spm_rw;
  logic [DATA_W/8-1:0] if_spm_be;
  logic [DATA_W-1:0]   if_spm_wr_data;
  logic [DATA_W-1:0]   if_spm_rd_data;
  logic                if_spm_rd_vld;

  logic [ADDR_W-1:0]   mem_spm_addr;
  logic                mem_spm_as_;
  logic                mem_spm_rw;
  logic [DATA_W/8-1:0] mem_spm_be;
  logic [DATA_W-1:0]   mem_spm_wr_data;
  logic [DATA_W-1:0]   mem_spm_rd_data;
  logic                mem_spm_rd_vld;

  logic                spm_ready;

  modport master (
    output if_spm_addr, if_spm_as_, if_spm_rw, if_spm_be, if_spm_wr_data,
    output mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_be, mem_spm_wr_data,
    input  if_spm_rd_data, if_spm_rd_vld, mem_spm_rd_data, mem_spm_rd_vld, spm_ready
  );

  modport slave (
    input  if_spm_addr, if_spm_as_, if_spm_rw, if_spm_be, if_spm_wr_data,
    input  mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_be, mem_spm_wr_data,
    output if_spm_rd_data, if_spm_rd_vld, mem_spm_rd_data, mem_spm_rd_vld, spm_ready
  );
endinterface

// File: rtl/spm_ram_core.sv
// True dual-port word array with byte-enable writes and one registered,
// read-first read port per side.
//   clk, reset           : clock, synchronous active-high reset (read registers only)
//   x_re / x_we          : read / write enable for port x (a or b)
//   x_addr, x_be, x_wdata: word address, byte enables, write data
//   x_rdata              : registered read data, held when no read occurs
// On a same-address write from both ports, port B's bytes land last and win.
module spm_ram_core #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_re,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_re,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // NOTE: the array has no reset branch so it maps onto plain RAM; zeroing is
  // done by the clear sequencer in the top level.
  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int i = 0; i < NB; i++)
        if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    if (b_we) begin
      for (int i = 0; i < NB; i++)
        if (b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  // Reading the array before the edge gives read-first behaviour.
  always_comb begin
    a_rdata_d = a_re ? mem[a_addr] : a_rdata_q;
    b_rdata_d = b_re ? mem[b_addr] : b_rdata_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/spm_dp_bank.sv
// Dual-port scratchpad bank: port A serves instruction fetch, port B load/store.
//   clk, reset : clock, synchronous active-high reset
//   bus        : spm_dp_bank_if slave (addresses, strobes, byte enables, data,
//                per-port read data/valid, spm_ready)
// After reset an optional sequencer zeroes every word before spm_ready rises.
// Read results appear RD_LAT (1 or 2) cycles after the request edge; a read that
// collides with the other port's write returns merged new data when FWD_EN = 1.
module spm_dp_bank
  import spm_dp_bank_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int FWD_EN     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          reset,
  spm_dp_bank_if.slave  bus
);
  localparam int NB = DATA_W / 8;

  function automatic logic [DATA_W-1:0] be_mask(input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++) be_mask[8*i +: 8] = {8{be[i]}};
  endfunction

  spm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_act;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_act   = 1'b0;
    case (state_q)
      RESET_ST: begin
        clr_cnt_d = '0;
        state_d   = (CLR_ON_RST != 0) ? CLEAR : IDLE;
      end
      CLEAR: begin
        clr_act   = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      IDLE:    ;
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_ST;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Strobes count only in IDLE and never on a reset edge.
  logic acc_ok, a_rd, a_wr, b_rd, b_wr;
  assign acc_ok = (state_q == IDLE) && !reset;
  assign a_rd   = acc_ok && (bus.if_spm_as_  == ENABLE_) && (bus.if_spm_rw  == READ);
  assign a_wr   = acc_ok && (bus.if_spm_as_  == ENABLE_) && (bus.if_spm_rw  == WRITE);
  assign b_rd   = acc_ok && (bus.mem_spm_as_ == ENABLE_) && (bus.mem_spm_rw == READ);
  assign b_wr   = acc_ok && (bus.mem_spm_as_ == ENABLE_) && (bus.mem_spm_rw == WRITE);
  assign bus.spm_ready = (state_q == IDLE);

  // The clear sequencer borrows port B's write path.
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [NB-1:0]     b_be;
  logic [DATA_W-1:0] b_wdata;
  always_comb begin
    b_we    = b_wr || clr_act;
    b_addr  = clr_act ? clr_cnt_q : bus.mem_spm_addr;
    b_be    = clr_act ? '1 : bus.mem_spm_be;
    b_wdata = clr_act ? '0 : bus.mem_spm_wr_data;
  end

  logic [DATA_W-1:0] core_rd_a, core_rd_b;
  spm_ram_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .reset  (reset),
    .a_re   (a_rd),
    .a_we   (a_wr),
    .a_addr (bus.if_spm_addr),
    .a_be   (bus.if_spm_be),
    .a_wdata(bus.if_spm_wr_data),
    .a_rdata(core_rd_a),
    .b_re   (b_rd),
    .b_we   (b_we),
    .b_addr (b_addr),
    .b_be   (b_be),
    .b_wdata(b_wdata),
    .b_rdata(core_rd_b)
  );

  // Collision capture: on each read, remember which bytes the other port wrote
  // to the same word in that cycle (zero mask when forwarding is off).
  logic [DATA_W-1:0] fwd_mask_a_q, fwd_mask_a_d, fwd_data_a_q, fwd_data_a_d;
  logic [DATA_W-1:0] fwd_mask_b_q, fwd_mask_b_d, fwd_data_b_q, fwd_data_b_d;
  logic              vld1_a_q, vld1_a_d, vld1_b_q, vld1_b_d;

  always_comb begin
    fwd_mask_a_d = fwd_mask_a_q;
    fwd_data_a_d = fwd_data_a_q;
    fwd_mask_b_d = fwd_mask_b_q;
    fwd_data_b_d = fwd_data_b_q;
    vld1_a_d     = a_rd;
    vld1_b_d     = b_rd;
    if (a_rd) begin
      fwd_mask_a_d = '0;
      fwd_data_a_d = bus.mem_spm_wr_data;
      if (FWD_EN != 0 && b_wr && bus.mem_spm_addr == bus.if_spm_addr)
        fwd_mask_a_d = be_mask(bus.mem_spm_be);
    end
    if (b_rd) begin
      fwd_mask_b_d = '0;
      fwd_data_b_d = bus.if_spm_wr_data;
      if (FWD_EN != 0 && a_wr && bus.if_spm_addr == bus.mem_spm_addr)
        fwd_mask_b_d = be_mask(bus.if_spm_be);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_mask_a_q <= '0;
      fwd_data_a_q <= '0;
      fwd_mask_b_q <= '0;
      fwd_data_b_q <= '0;
      vld1_a_q     <= 1'b0;
      vld1_b_q     <= 1'b0;
    end else begin
      fwd_mask_a_q <= fwd_mask_a_d;
      fwd_data_a_q <= fwd_data_a_d;
      fwd_mask_b_q <= fwd_mask_b_d;
      fwd_data_b_q <= fwd_data_b_d;
      vld1_a_q     <= vld1_a_d;
      vld1_b_q     <= vld1_b_d;
    end
  end

  logic [DATA_W-1:0] rd1_a, rd1_b;
  assign rd1_a = (core_rd_a & ~fwd_mask_a_q) | (fwd_data_a_q & fwd_mask_a_q);
  assign rd1_b = (core_rd_b & ~fwd_mask_b_q) | (fwd_data_b_q & fwd_mask_b_q);

  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    logic [DATA_W-1:0] rd2_a_q, rd2_a_d, rd2_b_q, rd2_b_d;
    logic              vld2_a_q, vld2_b_q;

    always_comb begin
      rd2_a_d = vld1_a_q ? rd1_a : rd2_a_q;
      rd2_b_d = vld1_b_q ? rd1_b : rd2_b_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd2_a_q  <= '0;
        rd2_b_q  <= '0;
        vld2_a_q <= 1'b0;
        vld2_b_q <= 1'b0;
      end else begin
        rd2_a_q  <= rd2_a_d;
        rd2_b_q  <= rd2_b_d;
        vld2_a_q <= vld1_a_q;
        vld2_b_q <= vld1_b_q;
      end
    end

    assign bus.if_spm_rd_data  = rd2_a_q;
    assign bus.if_spm_rd_vld   = vld2_a_q;
    assign bus.mem_spm_rd_data = rd2_b_q;
    assign bus.mem_spm_rd_vld  = vld2_b_q;
  end else begin : g_lat1
    assign bus.if_spm_rd_data  = rd1_a;
    assign bus.if_spm_rd_vld   = vld1_a_q;
    assign bus.mem_spm_rd_data = rd1_b;
    assign bus.mem_spm_rd_vld  = vld1_b_q;
  end
endmodule

// File: tb/tb_spm_dp_bank.sv
// Bench for spm_dp_bank: two instances share one stimulus stream,
// dut0 = RD_LAT 1 / FWD_EN 1, dut1 = RD_LAT 2 / FWD_EN 0, both 16 words.
// A word-array model predicts each read; a negedge monitor pops and compares.
module tb_spm_dp_bank;
  import spm_dp_bank_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  typedef enum {OP_NOP, OP_RD, OP_WR} op_e;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spm_dp_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  spm_dp_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  spm_dp_bank #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FWD_EN(1), .CLR_ON_RST(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  spm_dp_bank #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .FWD_EN(0), .CLR_ON_RST(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Queue index: 0 dut0 port A, 1 dut0 port B, 2 dut1 port A, 3 dut1 port B.
  exp_t        exp_q [4][$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd [4];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        rst_prev = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] be);
    logic [31:0] w = old;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = dat[8*i +: 8];
    return w;
  endfunction

  // Monitor: right after a reset edge every output must be at its reset value;
  // otherwise each valid pops one prediction and idle cycles must hold data.
  always @(negedge clk) begin
    logic        vld [4];
    logic [31:0] dat [4];
    exp_t        e;
    vld[0] = bus0.if_spm_rd_vld;  dat[0] = bus0.if_spm_rd_data;
    vld[1] = bus0.mem_spm_rd_vld; dat[1] = bus0.mem_spm_rd_data;
    vld[2] = bus1.if_spm_rd_vld;  dat[2] = bus1.if_spm_rd_data;
    vld[3] = bus1.mem_spm_rd_vld; dat[3] = bus1.mem_spm_rd_data;
    if (rst_prev) begin
      check("rst_ready0", {31'b0, bus0.spm_ready}, 32'd0);
      check("rst_ready1", {31'b0, bus1.spm_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rst_vld%0d", i), {31'b0, vld[i]}, 32'd0);
        check($sformatf("rst_data%0d", i), dat[i], 32'd0);
        last_rd[i] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("spurious_vld%0d", i), {31'b0, vld[i]}, 32'd0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("rd_data%0d", i), dat[i], e.data);
            check($sformatf("rd_latency%0d", i), cyc, e.cyc);
          end
          last_rd[i] = dat[i];
        end else begin
          check($sformatf("rd_hold%0d", i), dat[i], last_rd[i]);
        end
      end
    end
  end

  task automatic set_ports(input op_e aop, input logic [3:0] aaddr, input logic [3:0] abe,
                           input logic [31:0] adat, input op_e bop, input logic [3:0] baddr,
                           input logic [3:0] bbe, input logic [31:0] bdat);
    bus0.if_spm_as_      = (aop == OP_NOP);  bus1.if_spm_as_      = (aop == OP_NOP);
    bus0.if_spm_rw       = (aop != OP_WR);   bus1.if_spm_rw       = (aop != OP_WR);
    bus0.if_spm_addr     = aaddr;            bus1.if_spm_addr     = aaddr;
    bus0.if_spm_be       = abe;              bus1.if_spm_be       = abe;
    bus0.if_spm_wr_data  = adat;             bus1.if_spm_wr_data  = adat;
    bus0.mem_spm_as_     = (bop == OP_NOP);  bus1.mem_spm_as_     = (bop == OP_NOP);
    bus0.mem_spm_rw      = (bop != OP_WR);   bus1.mem_spm_rw      = (bop != OP_WR);
    bus0.mem_spm_addr    = baddr;            bus1.mem_spm_addr    = baddr;
    bus0.mem_spm_be      = bbe;              bus1.mem_spm_be      = bbe;
    bus0.mem_spm_wr_data = bdat;             bus1.mem_spm_wr_data = bdat;
  endtask

  // One accepted cycle: predict reads (forwarded for dut0, pre-write for dut1),
  // update the model (A first, then B so B wins overlapping bytes), drive, clock.
  task automatic step(input op_e aop, input logic [3:0] aaddr, input logic [3:0] abe,
                      input logic [31:0] adat, input op_e bop, input logic [3:0] baddr,
                      input logic [3:0] bbe, input logic [31:0] bdat);
    logic [31:0] old;
    if (aop == OP_RD) begin
      old = ref_mem[aaddr];
      exp_q[0].push_back('{(bop == OP_WR && baddr == aaddr) ? merge(old, bdat, bbe) : old, cyc + 1});
      exp_q[2].push_back('{old, cyc + 2});
    end
    if (bop == OP_RD) begin
      old = ref_mem[baddr];
      exp_q[1].push_back('{(aop == OP_WR && aaddr == baddr) ? merge(old, adat, abe) : old, cyc + 1});
      exp_q[3].push_back('{old, cyc + 2});
    end
    if (aop == OP_WR) ref_mem[aaddr] = merge(ref_mem[aaddr], adat, abe);
    if (bop == OP_WR) ref_mem[baddr] = merge(ref_mem[baddr], bdat, bbe);
    set_ports(aop, aaddr, abe, adat, bop, baddr, bbe, bdat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_NOP, 4'd0, 4'd0, 32'd0, OP_NOP, 4'd0, 4'd0, 32'd0);
  endtask

  // Strobes that must be ignored while not ready: writes to words 0 and 1,
  // which a correct clear has already passed by the later cycles.
  task automatic blocked_strobe(input int i);
    set_ports((i % 2 != 0) ? OP_RD : OP_WR, 4'd0, 4'hF, 32'hFFFF_FFFF,
              (i % 2 != 0) ? OP_WR : OP_RD, 4'd1, 4'hF, 32'hA5A5_A5A5);
  endtask

  task automatic clear_window(output int low0, output int low1);
    low0 = 0;
    low1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) blocked_strobe(i);
      else set_ports(OP_NOP, 4'd0, 4'd0, 32'd0, OP_NOP, 4'd0, 4'd0, 32'd0);
      @(posedge clk);
      #1;
      if (!bus0.spm_ready) low0++;
      if (!bus1.spm_ready) low1++;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++)
      step(OP_RD, 4'(a), 4'hF, 32'd0, OP_RD, 4'(DEPTH - 1 - a), 4'hF, 32'd0);
  endtask

  initial begin
    int l0, l1;
    set_ports(OP_NOP, 4'd0, 4'd0, 32'd0, OP_NOP, 4'd0, 4'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Power-up clear: ready stays low for exactly DEPTH cycles, strobes ignored.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_window(l0, l1);
    check("ready_low_cycles_dut0", l0, 32'd16);
    check("ready_low_cycles_dut1", l1, 32'd16);
    read_all();

    // Full-word write/read on A, then a be = 0 write that must change nothing.
    step(OP_WR, 4'h3, 4'hF, 32'hDEAD_BEEF, OP_NOP, 4'h0, 4'h0, 32'h0);
    step(OP_RD, 4'h3, 4'hF, 32'h0, OP_NOP, 4'h0, 4'h0, 32'h0);
    step(OP_WR, 4'h3, 4'h0, 32'hFFFF_FFFF, OP_NOP, 4'h0, 4'h0, 32'h0);
    step(OP_RD, 4'h3, 4'h0, 32'h0, OP_RD, 4'h3, 4'h0, 32'h0);

    // Byte-enable merge on B.
    step(OP_NOP, 4'h0, 4'h0, 32'h0, OP_WR, 4'h5, 4'hF, 32'h1122_3344);
    step(OP_NOP, 4'h0, 4'h0, 32'h0, OP_WR, 4'h5, 4'h1, 32'h0000_00AA);
    step(OP_RD, 4'h5, 4'hF, 32'h0, OP_RD, 4'h5, 4'hF, 32'h0);

    // Write/write collision: B wins; then partial-overlap merge.
    step(OP_WR, 4'h7, 4'hF, 32'h1111_1111, OP_WR, 4'h7, 4'hF, 32'h2222_2222);
    step(OP_RD, 4'h7, 4'hF, 32'h0, OP_RD, 4'h7, 4'hF, 32'h0);
    step(OP_WR, 4'h7, 4'h3, 32'h3333_3333, OP_WR, 4'h7, 4'h6, 32'h4444_4444);
    step(OP_RD, 4'h7, 4'hF, 32'h0, OP_NOP, 4'h0, 4'h0, 32'h0);

    // Read/write collisions in both directions, then read-after-write.
    step(OP_WR, 4'h9, 4'hF, 32'h0, OP_NOP, 4'h0, 4'h0, 32'h0);
    step(OP_WR, 4'h9, 4'hF, 32'h55, OP_RD, 4'h9, 4'hF, 32'h0);
    step(OP_RD, 4'h9, 4'hF, 32'h0, OP_WR, 4'h9, 4'h2, 32'h0000_7700);
    step(OP_RD, 4'h9, 4'hF, 32'h0, OP_RD, 4'h9, 4'hF, 32'h0);

    // Random traffic over a small address space so collisions are frequent.
    for (int n = 0; n < 400; n++)
      step(op_e'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom),
           32'($urandom), op_e'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
           4'($urandom), 32'($urandom));
    idle(4);

    // Reset, let the clear reach address 6, reset again: the sequence must
    // restart from 0 and take the full DEPTH cycles; strobes stay ignored.
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      blocked_strobe(i);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    set_ports(OP_NOP, 4'd0, 4'd0, 32'd0, OP_NOP, 4'd0, 4'd0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_window(l0, l1);
    check("restart_ready_low_dut0", l0, 32'd16);
    check("restart_ready_low_dut1", l1, 32'd16);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    read_all();
    idle(4);

    for (int i = 0; i < 4; i++)
      check($sformatf("pending_reads%0d", i), exp_q[i].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
